// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
// Bundles the run-control button inputs, the breakpoint/PC inputs and the
// CPU control outputs of cpu_run_ctrl.
//   master : environment side (drives buttons, breakpoint and pc; observes outputs)
//   slave  : cpu_run_ctrl side
// Signals:
//   run_btn, halt_btn, step_btn, soft_rst_btn : request levels, act on rising edge
//   bp_en, bp_addr[31:0]                       : breakpoint enable and PC
//   pc[31:0]                                   : current CPU fetch address
//   cpu_en                                     : CPU clock-enable (combinational)
//   cpu_rst                                    : CPU reset (registered)
//   state[1:0]                                 : HOLD=00 RUN=01 HALT=10 STEP=11
//   step_done                                  : one-cycle pulse after a step
//   cycle_count[31:0]                          : number of cycles with cpu_en=1
interface cpu_run_ctrl_if;
    logic        run_btn;
    logic        halt_btn;
    logic        step_btn;
    logic        soft_rst_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        cpu_en;
    logic        cpu_rst;
    logic [1:0]  state;
    logic        step_done;
    logic [31:0] cycle_count;

    modport master (
        output run_btn, halt_btn, step_btn, soft_rst_btn, bp_en, bp_addr, pc,
        input  cpu_en, cpu_rst, state, step_done, cycle_count
    );

    modport slave (
        input  run_btn, halt_btn, step_btn, soft_rst_btn, bp_en, bp_addr, pc,
        output cpu_en, cpu_rst, state, step_done, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/halt/single-step controller for a soft CPU. After any reset event the
// CPU is held in reset for HOLD_CYCLES cycles, then enters RUN (AUTO_RUN=1)
// or HALT (AUTO_RUN=0). Button requests act on rising edges; a breakpoint
// comparator stops the CPU before it executes the instruction at bp_addr.
// Ports:
//   clock : system clock, all state updates on its rising edge
//   reset : synchronous active-high reset
//   bus   : cpu_run_ctrl_if.slave (buttons, breakpoint, pc in; cpu control out)
module cpu_run_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter bit AUTO_RUN    = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);

    // Button vector bit positions
    localparam int BTN_RUN  = 0;
    localparam int BTN_HALT = 1;
    localparam int BTN_STEP = 2;
    localparam int BTN_SOFT = 3;

    state_t            state_reg;
    logic [CNT_W-1:0]  hold_cnt_reg;
    logic              cpu_rst_reg;
    logic              step_done_reg;
    logic [31:0]       cycle_count_reg;
    logic              bp_skip_reg;
    logic [3:0]        btn_prev_reg;

    logic [3:0]        btn_now;
    logic [3:0]        btn_edge;
    logic              bp_hit;
    logic              cpu_en_next;

    assign btn_now = {bus.soft_rst_btn, bus.step_btn, bus.halt_btn, bus.run_btn};

    // Rising-edge detect; prev registers reset to 1 so a button held through
    // reset does not register as a press.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign btn_edge[gi] = btn_now[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    // cpu_en must be combinational so a halt edge or breakpoint stops the CPU
    // in the very cycle it is seen, before the instruction at pc executes.
    always_comb begin
        bp_hit      = 1'b0;
        cpu_en_next = 1'b0;
        case (state_reg)
            ST_RUN: begin
                bp_hit      = bus.bp_en & (bus.pc == bus.bp_addr) & ~bp_skip_reg;
                cpu_en_next = ~btn_edge[BTN_HALT] & ~bp_hit;
            end
            ST_STEP: cpu_en_next = 1'b1;
            default: cpu_en_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_HOLD;
            hold_cnt_reg    <= HOLD_INIT;
            cpu_rst_reg     <= 1'b1;
            step_done_reg   <= 1'b0;
            cycle_count_reg <= 32'd0;
            bp_skip_reg     <= 1'b0;
            btn_prev_reg    <= '1;
        end else begin
            btn_prev_reg  <= btn_now;
            step_done_reg <= (state_reg == ST_STEP);

            // The skip only covers the first RUN cycle after resuming.
            if (state_reg == ST_RUN) begin
                bp_skip_reg <= 1'b0;
            end

            if (btn_edge[BTN_SOFT] || (state_reg == ST_HOLD)) begin
                cycle_count_reg <= 32'd0;
            end else if (cpu_en_next) begin
                cycle_count_reg <= cycle_count_reg + 32'd1;
            end

            cpu_rst_reg <= 1'b0;
            if (btn_edge[BTN_SOFT]) begin
                state_reg    <= ST_HOLD;
                hold_cnt_reg <= HOLD_INIT;
                cpu_rst_reg  <= 1'b1;
            end else begin
                case (state_reg)
                    ST_HOLD: begin
                        if (hold_cnt_reg != '0) begin
                            hold_cnt_reg <= hold_cnt_reg - CNT_W'(1);
                        end
                        if (hold_cnt_reg <= CNT_W'(1)) begin
                            state_reg <= AUTO_RUN ? ST_RUN : ST_HALT;
                        end else begin
                            cpu_rst_reg <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (btn_edge[BTN_HALT] || bp_hit) begin
                            state_reg <= ST_HALT;
                        end
                    end
                    ST_HALT: begin
                        if (btn_edge[BTN_STEP]) begin
                            state_reg <= ST_STEP;
                        end else if (btn_edge[BTN_RUN]) begin
                            state_reg   <= ST_RUN;
                            bp_skip_reg <= 1'b1;
                        end
                    end
                    ST_STEP: state_reg <= ST_HALT;
                    default: state_reg <= ST_HALT;
                endcase
            end
        end
    end

    assign bus.cpu_en      = cpu_en_next;
    assign bus.cpu_rst     = cpu_rst_reg;
    assign bus.state       = state_reg;
    assign bus.step_done   = step_done_reg;
    assign bus.cycle_count = cycle_count_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;

    localparam int HOLD = 4;
    localparam logic [1:0] S_HOLD = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HALT = 2'b10;
    localparam logic [1:0] S_STEP = 2'b11;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    cpu_run_ctrl_if bus();

    cpu_run_ctrl #(.HOLD_CYCLES(HOLD), .AUTO_RUN(1'b0)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the controller plus a trivial CPU whose pc
    // advances by 4 on every enabled cycle and returns to 0 while in reset.
    logic [1:0]  m_state;
    int          m_hold;
    bit          m_skip;
    logic [31:0] m_count;
    bit [3:0]    m_prev;
    bit          m_sd;
    logic [31:0] cpu_pc = 32'd0;

    bit          bp_en_v   = 1'b0;
    logic [31:0] bp_addr_v = 32'd0;

    // Expectations for the current cycle
    bit          x_run, x_halt, x_step, x_soft, x_bp;
    bit          e_en, e_rst, e_sd;
    logic [1:0]  e_state;
    logic [31:0] e_count;
    bit [3:0]    cur_btn;
    bit          in_reset;

    task automatic apply(input bit r, input bit h, input bit s, input bit so, input bit rs);
        reset            = rs;
        bus.run_btn      = r;
        bus.halt_btn     = h;
        bus.step_btn     = s;
        bus.soft_rst_btn = so;
        bus.bp_en        = bp_en_v;
        bus.bp_addr      = bp_addr_v;
        bus.pc           = cpu_pc;
        cur_btn  = {so, s, h, r};
        in_reset = rs;
        x_run  = r  && !m_prev[0];
        x_halt = h  && !m_prev[1];
        x_step = s  && !m_prev[2];
        x_soft = so && !m_prev[3];
        x_bp   = (m_state == S_RUN) && bp_en_v && (cpu_pc == bp_addr_v) && !m_skip;
        e_en    = (m_state == S_STEP) || ((m_state == S_RUN) && !x_halt && !x_bp);
        e_state = m_state;
        e_rst   = (m_state == S_HOLD);
        e_sd    = m_sd;
        e_count = m_count;
        #1;
    endtask

    task automatic tick();
        logic [1:0] ns;
        @(posedge clock);
        if (e_rst) cpu_pc = 32'd0;
        else if (e_en) cpu_pc = cpu_pc + 32'd4;
        if (in_reset) begin
            m_state = S_HOLD;
            m_hold  = HOLD;
            m_skip  = 1'b0;
            m_count = 32'd0;
            m_sd    = 1'b0;
            m_prev  = 4'b1111;
        end else begin
            ns      = m_state;
            m_sd    = (m_state == S_STEP);
            m_count = (x_soft || m_state == S_HOLD) ? 32'd0 : m_count + {31'd0, e_en};
            if (m_state == S_RUN) m_skip = 1'b0;
            if (x_soft) begin
                ns     = S_HOLD;
                m_hold = HOLD;
            end else begin
                case (m_state)
                    S_HOLD: begin
                        if (m_hold <= 1) ns = S_HALT;
                        m_hold = m_hold - 1;
                    end
                    S_RUN:  if (x_halt || x_bp) ns = S_HALT;
                    S_HALT: begin
                        if (x_step) ns = S_STEP;
                        else if (x_run) begin
                            ns     = S_RUN;
                            m_skip = 1'b1;
                        end
                    end
                    default: ns = S_HALT;
                endcase
            end
            m_state = ns;
            m_prev  = cur_btn;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        int rst_cycles = 0;
        apply(1, 1, 1, 1, 1);
        tick();
        apply(1, 1, 1, 1, 0);
        checks++;
        if (bus.state !== S_HOLD || bus.cpu_rst !== 1'b1 || bus.cpu_en !== 1'b0 ||
            bus.step_done !== 1'b0 || bus.cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_state got state=%b rst=%b en=%b sd=%b cnt=%h exp state=00 rst=1 en=0 sd=0 cnt=0",
                     bus.state, bus.cpu_rst, bus.cpu_en, bus.step_done, bus.cycle_count);
        end
        // Buttons stay held after reset: none of them may fire.
        for (int i = 0; i < HOLD + 3; i++) begin
            apply(1, 1, 1, 1, 0);
            if (bus.cpu_rst === 1'b1) rst_cycles++;
            checks++;
            if (bus.state !== e_state || bus.cpu_en !== 1'b0) begin
                failures++;
                $display("FAIL hold_seq cycle %0d got state=%b en=%b exp state=%b en=0", i, bus.state, bus.cpu_en, e_state);
            end
            tick();
        end
        checks++;
        if (rst_cycles != HOLD) begin
            failures++;
            $display("FAIL hold_len got cpu_rst cycles=%0d exp %0d", rst_cycles, HOLD);
        end
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_HALT || bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL after_hold got state=%b en=%b exp state=10 en=0", bus.state, bus.cpu_en);
        end
        tick();
        $display("reset: cpu_rst held %0d cycles, state=%b", rst_cycles, bus.state);
    endtask

    task automatic test_breakpoint();
        int i;
        bp_en_v   = 1'b1;
        bp_addr_v = 32'h10;
        apply(1, 0, 0, 0, 0);
        tick();
        for (i = 0; i < 12 && cpu_pc != 32'h10; i++) begin
            apply(0, 0, 0, 0, 0);
            checks++;
            if (bus.cpu_en !== e_en || bus.state !== S_RUN) begin
                failures++;
                $display("FAIL bp_approach pc=%h got en=%b state=%b exp en=%b state=01", cpu_pc, bus.cpu_en, bus.state, e_en);
            end
            tick();
        end
        checks++;
        if (i >= 12) begin
            failures++;
            $display("FAIL bp_reach got pc=%h exp 00000010 within 12 cycles", cpu_pc);
        end
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_hit_en got en=%b exp 0 at pc=%h", bus.cpu_en, cpu_pc);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_HALT || bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_halt got state=%b en=%b exp state=10 en=0", bus.state, bus.cpu_en);
        end
        tick();
        apply(1, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_RUN || bus.cpu_en !== 1'b1 || cpu_pc !== 32'h10) begin
            failures++;
            $display("FAIL bp_resume got state=%b en=%b pc=%h exp state=01 en=1 pc=00000010", bus.state, bus.cpu_en, cpu_pc);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.cpu_en !== 1'b1 || cpu_pc !== 32'h14) begin
            failures++;
            $display("FAIL bp_advance got en=%b pc=%h exp en=1 pc=00000014", bus.cpu_en, cpu_pc);
        end
        tick();
        apply(0, 1, 0, 0, 0);
        checks++;
        if (bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_edge_en got en=%b exp 0", bus.cpu_en);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        tick();
        bp_en_v = 1'b0;
        $display("breakpoint: halted at 0x10, resumed, state=%b pc=%h", bus.state, cpu_pc);
    endtask

    task automatic test_step(input bit with_run);
        logic [31:0] c0;
        c0 = m_count;
        apply(with_run, 0, 1, 0, 0);
        checks++;
        if (bus.state !== S_HALT || bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL step_req got state=%b en=%b exp state=10 en=0", bus.state, bus.cpu_en);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_STEP || bus.cpu_en !== 1'b1) begin
            failures++;
            $display("FAIL step_exec got state=%b en=%b exp state=11 en=1", bus.state, bus.cpu_en);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_HALT || bus.cpu_en !== 1'b0 || bus.step_done !== 1'b1 ||
            bus.cycle_count !== c0 + 32'd1) begin
            failures++;
            $display("FAIL step_done got state=%b en=%b sd=%b cnt=%h exp state=10 en=0 sd=1 cnt=%h",
                     bus.state, bus.cpu_en, bus.step_done, bus.cycle_count, c0 + 32'd1);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.step_done !== 1'b0 || bus.state !== S_HALT) begin
            failures++;
            $display("FAIL step_pulse got sd=%b state=%b exp sd=0 state=10", bus.step_done, bus.state);
        end
        tick();
        $display("step (run_btn=%0d): cnt %h -> %h", with_run, c0, bus.cycle_count);
    endtask

    task automatic test_wrap();
        apply(0, 0, 0, 0, 0);
        force dut.cycle_count_reg = 32'hFFFF_FFFF;
        tick();
        release dut.cycle_count_reg;
        m_count = 32'hFFFF_FFFF;
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.cycle_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload got cnt=%h exp ffffffff", bus.cycle_count);
        end
        tick();
        apply(0, 0, 1, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL wrap got cnt=%h exp 00000000", bus.cycle_count);
        end
        tick();
        $display("wrap: cnt=%h", bus.cycle_count);
    endtask

    task automatic test_soft_rst();
        int rst_cycles = 0;
        apply(1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0);
            tick();
        end
        apply(0, 1, 0, 1, 0);
        checks++;
        if (bus.state !== S_RUN || bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL soft_halt_en got state=%b en=%b exp state=01 en=0", bus.state, bus.cpu_en);
        end
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_HOLD || bus.cycle_count !== 32'd0 || bus.cpu_rst !== 1'b1) begin
            failures++;
            $display("FAIL soft_hold got state=%b cnt=%h rst=%b exp state=00 cnt=0 rst=1", bus.state, bus.cycle_count, bus.cpu_rst);
        end
        for (int i = 0; i < HOLD + 2; i++) begin
            apply(0, 0, 0, 0, 0);
            if (bus.cpu_rst === 1'b1) rst_cycles++;
            tick();
        end
        apply(0, 0, 0, 0, 0);
        checks++;
        if (rst_cycles != HOLD || bus.state !== S_HALT) begin
            failures++;
            $display("FAIL soft_hold_len got rst cycles=%0d state=%b exp %0d state=10", rst_cycles, bus.state, HOLD);
        end
        tick();
        $display("soft_rst: cpu_rst held %0d cycles", rst_cycles);
    endtask

    task automatic test_reset_mid_run();
        apply(1, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 0);
        tick();
        apply(0, 0, 0, 0, 1);
        tick();
        apply(0, 0, 0, 0, 0);
        checks++;
        if (bus.state !== S_HOLD || bus.cpu_rst !== 1'b1 || bus.cycle_count !== 32'd0 || bus.cpu_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_run_reset got state=%b rst=%b cnt=%h en=%b exp state=00 rst=1 cnt=0 en=0",
                     bus.state, bus.cpu_rst, bus.cycle_count, bus.cpu_en);
        end
        for (int i = 0; i < HOLD; i++) begin
            apply(0, 0, 0, 0, 0);
            tick();
        end
        $display("reset_mid_run: state=%b", bus.state);
    endtask

    task automatic test_random();
        bit r, h, s, so, rs;
        bp_addr_v = 32'h40;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 5) == 0);
            s  = ($urandom_range(0, 4) == 0);
            so = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 99) == 0);
            bp_en_v = ($urandom_range(0, 1) == 1);
            apply(r, h, s, so, rs);
            checks++;
            if (bus.state !== e_state || bus.cpu_en !== e_en || bus.cpu_rst !== e_rst ||
                bus.step_done !== e_sd || bus.cycle_count !== e_count) begin
                failures++;
                $display("FAIL random txn %0d got state=%b en=%b rst=%b sd=%b cnt=%h exp state=%b en=%b rst=%b sd=%b cnt=%h",
                         i, bus.state, bus.cpu_en, bus.cpu_rst, bus.step_done, bus.cycle_count,
                         e_state, e_en, e_rst, e_sd, e_count);
            end
            $display("txn %0d: btn=%b rst=%b pc=%h state=%b en=%b cnt=%0d", i, cur_btn, rs, cpu_pc, bus.state, bus.cpu_en, bus.cycle_count);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_breakpoint();
        test_step(1'b0);
        test_step(1'b1);
        test_wrap();
        test_soft_rst();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
